// File: rtl/phj_pkg.sv
// Shared types and helpers for the partitioned hash-join fan-in blocks.
package phj_pkg;

  localparam int unsigned COUNT_WIDTH = 32;
  localparam int unsigned MAX_INPUTS  = 16;
  localparam int unsigned MAX_IDX_W   = 4;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or after ptr, wrapping within the low n bits.
  function automatic rr_pick_t rr_pick(input logic [MAX_INPUTS-1:0] req,
                                       input logic [MAX_IDX_W-1:0]  ptr,
                                       input int unsigned           n);
    rr_pick_t    pick;
    int unsigned k;
    pick = '0;
    for (int unsigned off = 0; off < MAX_INPUTS; off++) begin
      k = 32'(ptr) + off;
      if (k >= n) k = k - n;
      if ((off < n) && !pick.found && req[k[MAX_IDX_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = k[MAX_IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after ptr, wrapping modulo N.
module rr_arbiter
  import phj_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant_onehot,
  output logic [IdxW-1:0] grant_idx,
  output logic            found
);

  rr_pick_t pick;

  // Rotating-priority search, expanded to one-hot for the ready vector.
  always_comb begin
    pick         = rr_pick(MAX_INPUTS'(req), MAX_IDX_W'(ptr), N);
    found        = pick.found;
    grant_idx    = pick.idx[IdxW-1:0];
    grant_onehot = '0;
    if (pick.found) grant_onehot[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/partition_gate_rr.sv
// N-input partition gate: forwards tuples whose tag select field equals ID,
// round-robin arbitration, 2-entry skid output buffer, emitted-tuple counter.
module partition_gate_rr
  import phj_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TAG_WIDTH  = 32,
  parameter int unsigned SEL_LSB    = 0,
  parameter int unsigned SEL_BITS   = 1,
  parameter int unsigned ID         = 0,
  localparam int unsigned SrcW = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS*TAG_WIDTH-1:0]  in_tag,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [TAG_WIDTH-1:0]             out_tag,
  output logic [SrcW-1:0]                  out_src,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [COUNT_WIDTH-1:0]           tuple_count
);

  localparam logic [SEL_BITS-1:0] IdSel = SEL_BITS'(ID);

  buf_state_t             state_q;
  logic [SrcW-1:0]        rr_ptr_q;
  logic [SrcW-1:0]        rr_ptr_next;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [DATA_WIDTH-1:0]  main_data_q, skid_data_q, sel_data;
  logic [TAG_WIDTH-1:0]   main_tag_q, skid_tag_q, sel_tag;
  logic [SrcW-1:0]        main_src_q, skid_src_q;

  logic [NUM_INPUTS-1:0]  match;
  logic [NUM_INPUTS-1:0]  grant_onehot;
  logic [SrcW-1:0]        grant_idx;
  logic                   found;
  logic                   accept_en;
  logic                   in_fire;
  logic                   out_fire;

  // Only valid channels whose select field carries our partition ID compete.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      match[i] = in_valid[i] && (in_tag[i*TAG_WIDTH + SEL_LSB +: SEL_BITS] == IdSel);
    end
  end

  rr_arbiter #(
    .N (NUM_INPUTS)
  ) u_arb (
    .req          (match),
    .ptr          (rr_ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .found        (found)
  );

  // Acceptance depends on registered state only; out_ready never reaches in_ready.
  always_comb begin
    accept_en   = resetn && (state_q != FULL);
    in_ready    = accept_en ? grant_onehot : '0;
    in_fire     = accept_en && found;
    out_fire    = out_valid && out_ready;
    rr_ptr_next = (grant_idx == SrcW'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Payload/tag mux for the granted channel.
  always_comb begin
    sel_data = '0;
    sel_tag  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_onehot[i]) begin
        sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tag  = in_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  // Skid-buffer FSM, round-robin pointer and output counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= EMPTY;
      rr_ptr_q    <= '0;
      count_q     <= '0;
      main_data_q <= '0;
      main_tag_q  <= '0;
      main_src_q  <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      skid_src_q  <= '0;
    end else begin
      if (in_fire) rr_ptr_q <= rr_ptr_next;
      if (out_fire) count_q <= count_q + 1'b1;
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_data_q <= sel_data;
            main_tag_q  <= sel_tag;
            main_src_q  <= grant_idx;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_q <= sel_data;
            main_tag_q  <= sel_tag;
            main_src_q  <= grant_idx;
          end else if (in_fire) begin
            skid_data_q <= sel_data;
            skid_tag_q  <= sel_tag;
            skid_src_q  <= grant_idx;
            state_q     <= FULL;
          end else if (out_fire) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data_q <= skid_data_q;
            main_tag_q  <= skid_tag_q;
            main_src_q  <= skid_src_q;
            state_q     <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign out_valid   = (state_q != EMPTY);
  assign out_data    = main_data_q;
  assign out_tag     = main_tag_q;
  assign out_src     = main_src_q;
  assign tuple_count = count_q;

endmodule

// File: tb/tb_partition_gate_rr.sv
// Bench for partition_gate_rr: two instances (ID=1/bit0 select, ID=5/bits[6:4])
// checked every cycle against a queue model, plus directed literal checks.
module tb_partition_gate_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn;
  logic [1:0][255:0] in_data;
  logic [1:0][127:0] in_tag;
  logic [1:0][3:0]   in_valid;
  logic [1:0][3:0]   in_ready;
  logic [1:0][63:0]  out_data;
  logic [1:0][31:0]  out_tag;
  logic [1:0][1:0]   out_src;
  logic [1:0]        out_valid;
  logic [1:0]        out_ready;
  logic [1:0][31:0]  tuple_count;

  partition_gate_rr #(
    .NUM_INPUTS (4), .DATA_WIDTH (64), .TAG_WIDTH (32),
    .SEL_LSB    (0), .SEL_BITS   (1),  .ID        (1)
  ) dut_a (
    .clk (clk), .resetn (resetn),
    .in_data (in_data[0]), .in_tag (in_tag[0]), .in_valid (in_valid[0]),
    .in_ready (in_ready[0]), .out_data (out_data[0]), .out_tag (out_tag[0]),
    .out_src (out_src[0]), .out_valid (out_valid[0]), .out_ready (out_ready[0]),
    .tuple_count (tuple_count[0])
  );

  partition_gate_rr #(
    .NUM_INPUTS (4), .DATA_WIDTH (64), .TAG_WIDTH (32),
    .SEL_LSB    (4), .SEL_BITS   (3),  .ID        (5)
  ) dut_b (
    .clk (clk), .resetn (resetn),
    .in_data (in_data[1]), .in_tag (in_tag[1]), .in_valid (in_valid[1]),
    .in_ready (in_ready[1]), .out_data (out_data[1]), .out_tag (out_tag[1]),
    .out_src (out_src[1]), .out_valid (out_valid[1]), .out_ready (out_ready[1]),
    .tuple_count (tuple_count[1])
  );

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Model: up to two buffered tuples per instance, in order.
  int          m_n   [2];
  logic [63:0] m_d   [2][2];
  logic [31:0] m_t   [2][2];
  int          m_s   [2][2];
  int          m_ptr [2];
  logic [31:0] m_cnt [2];

  logic [1:0][3:0] hs;
  int          seq [2][4];
  int          preload_tog = 0;
  int          preload_seen = 0;
  logic [31:0] preload_val = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_match(input int k, input logic [31:0] tag);
    if (k == 0) return tag[0] == 1'b1;
    return tag[6:4] == 3'd5;
  endfunction

  // Per-cycle compare against the model, then advance the model across the next edge.
  always @(negedge clk) begin : compare
    int          g;
    int          c;
    bit          fnd;
    logic [3:0]  exp_rdy;
    logic [31:0] tag;
    if (preload_tog != preload_seen) begin
      preload_seen = preload_tog;
      m_cnt[0] = preload_val;
    end
    for (int k = 0; k < 2; k++) begin
      fnd = 1'b0;
      g   = 0;
      if (resetn === 1'b1 && m_n[k] < 2) begin
        for (int o = 0; o < 4; o++) begin
          c   = (m_ptr[k] + o) % 4;
          tag = in_tag[k][c*32 +: 32];
          if (!fnd && in_valid[k][c] && m_match(k, tag)) begin
            fnd = 1'b1;
            g   = c;
          end
        end
      end
      exp_rdy = fnd ? (4'b0001 << g) : 4'b0000;
      if (started) begin
        chk($sformatf("in_ready[%0d]", k), 64'(in_ready[k]), 64'(exp_rdy));
        chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(m_n[k] > 0));
        if (m_n[k] > 0) begin
          chk($sformatf("out_data[%0d]", k), out_data[k], m_d[k][0]);
          chk($sformatf("out_tag[%0d]", k), 64'(out_tag[k]), 64'(m_t[k][0]));
          chk($sformatf("out_src[%0d]", k), 64'(out_src[k]), 64'(m_s[k][0]));
        end
        chk($sformatf("tuple_count[%0d]", k), 64'(tuple_count[k]), 64'(m_cnt[k]));
      end
      hs[k] = in_valid[k] & in_ready[k];
      if (resetn !== 1'b1) begin
        m_n[k]   = 0;
        m_ptr[k] = 0;
        m_cnt[k] = '0;
      end else begin
        if (m_n[k] > 0 && out_ready[k]) begin
          m_d[k][0] = m_d[k][1];
          m_t[k][0] = m_t[k][1];
          m_s[k][0] = m_s[k][1];
          m_n[k]    = m_n[k] - 1;
          m_cnt[k]  = m_cnt[k] + 1;
        end
        if (fnd) begin
          m_d[k][m_n[k]] = in_data[k][g*64 +: 64];
          m_t[k][m_n[k]] = in_tag[k][g*32 +: 32];
          m_s[k][m_n[k]] = g;
          m_n[k]   = m_n[k] + 1;
          m_ptr[k] = (g + 1) % 4;
        end
      end
    end
  end

  // Each channel presents a fresh payload {inst, channel, seq} after every accept.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (resetn !== 1'b1) seq[k][c] = 0;
        else if (hs[k][c]) seq[k][c] = seq[k][c] + 1;
        in_data[k][c*64 +: 64] = {8'(k), 8'(c), 48'(seq[k][c])};
      end
    end
  end

  task automatic rst();
    @(posedge clk);
    #1;
    resetn    = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] t;
    resetn    = 1'b0;
    in_tag    = '0;
    in_valid  = '0;
    out_ready = '0;
    rst();
    started = 1'b1;

    // Only odd tags match on instance A; ch0/ch2 alternate.
    in_tag[0]    = {32'h2, 32'h3, 32'h0, 32'h1};
    in_valid[0]  = 4'hF;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("t1_first_ready", 64'(in_ready[0]), 64'h1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("t1_src", 64'(out_src[0]), (j % 2 == 0) ? 64'd0 : 64'd2);
      chk("t1_tag", 64'(out_tag[0]), (j % 2 == 0) ? 64'h1 : 64'h3);
      chk("t1_reject", 64'(in_ready[0] & 4'b1010), 64'h0);
    end

    // All channels matching: strict rotation, one tuple per cycle.
    rst();
    in_tag[0]    = {32'h7, 32'h5, 32'h3, 32'h1};
    in_valid[0]  = 4'hF;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("t2_first_ready", 64'(in_ready[0]), 64'h1);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("t2_src", 64'(out_src[0]), 64'(j % 4));
      chk("t2_count", 64'(tuple_count[0]), 64'(j));
    end
    @(negedge clk);
    chk("t2_count8", 64'(tuple_count[0]), 64'd8);

    // Backpressure: two tuples fill the buffer, then drain in order.
    rst();
    in_tag[0]    = {32'h0, 32'h0, 32'h0, 32'h1};
    in_valid[0]  = 4'b0001;
    @(negedge clk);
    chk("t3_ready_n1", 64'(in_ready[0]), 64'h1);
    @(negedge clk);
    chk("t3_data_n2", out_data[0], 64'h0);
    @(negedge clk);
    chk("t3_full_ready", 64'(in_ready[0]), 64'h0);
    chk("t3_data_n3", out_data[0], 64'h0);
    @(negedge clk);
    chk("t3_hold_valid", 64'(out_valid[0]), 64'h1);
    chk("t3_hold_data", out_data[0], 64'h0);
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    @(negedge clk);
    chk("t3_drain0", out_data[0], 64'h0);
    chk("t3_drain_ready", 64'(in_ready[0]), 64'h0);
    @(negedge clk);
    chk("t3_drain1", out_data[0], 64'h1);
    @(posedge clk);
    #1 in_valid[0] = 4'b0000;
    @(negedge clk);
    chk("t3_drain2", out_data[0], 64'h2);
    @(negedge clk);
    chk("t3_empty", 64'(out_valid[0]), 64'h0);

    // Multi-bit select field on instance B, then a random sweep on both.
    rst();
    in_tag[1]    = {32'h60, 32'h51, 32'h40, 32'h50};
    in_valid[1]  = 4'hF;
    out_ready[1] = 1'b1;
    @(negedge clk);
    chk("t4_ready_50", 64'(in_ready[1]), 64'h1);
    @(negedge clk);
    chk("t4_ready_51", 64'(in_ready[1]), 64'h4);
    chk("t4_tag_50", 64'(out_tag[1]), 64'h50);
    @(negedge clk);
    chk("t4_ready_wrap", 64'(in_ready[1]), 64'h1);
    chk("t4_tag_51", 64'(out_tag[1]), 64'h51);
    for (int n = 0; n < 80; n++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        in_valid[k] = 4'($urandom);
        for (int c = 0; c < 4; c++) begin
          t      = $urandom;
          t[6:4] = 3'($urandom_range(4, 6));
          in_tag[k][c*32 +: 32] = t;
        end
        out_ready[k] = ($urandom_range(0, 3) != 0);
      end
    end

    // Reset while FULL with the pointer past the lowest matching channel.
    rst();
    in_tag[0]   = {32'h1, 32'h0, 32'h3, 32'h0};
    in_valid[0] = 4'b0010;
    @(negedge clk);
    chk("t5_ready_a", 64'(in_ready[0]), 64'h2);
    @(negedge clk);
    chk("t5_ready_b", 64'(in_ready[0]), 64'h2);
    @(posedge clk);
    #1;
    in_valid[0] = 4'b1010;
    resetn      = 1'b0;
    @(negedge clk);
    chk("t5_rst_ready", 64'(in_ready[0]), 64'h0);
    chk("t5_prerst_valid", 64'(out_valid[0]), 64'h1);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("t5_post_valid", 64'(out_valid[0]), 64'h0);
    chk("t5_post_count", 64'(tuple_count[0]), 64'h0);
    chk("t5_post_data", out_data[0], 64'h0);
    chk("t5_post_grant", 64'(in_ready[0]), 64'h2);
    out_ready[0] = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("t5_mid_count", 64'(tuple_count[0]), 64'h0);
    chk("t5_mid_valid", 64'(out_valid[0]), 64'h0);

    // Counter wrap from a preloaded value.
    rst();
    @(posedge clk);
    #1;
    force dut_a.count_q = 32'hFFFF_FFFE;
    preload_val = 32'hFFFF_FFFE;
    preload_tog = preload_tog + 1;
    @(negedge clk);
    chk("t6_preload", 64'(tuple_count[0]), 64'hFFFF_FFFE);
    @(posedge clk);
    #1;
    release dut_a.count_q;
    in_tag[0]    = {32'h0, 32'h0, 32'h0, 32'h1};
    in_valid[0]  = 4'b0001;
    out_ready[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid[0] = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    chk("t6_wrap", 64'(tuple_count[0]), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
